// File: rtl/demux_1x16.sv
// -----------------------------------------------------------------------------
// demux_1x16
//   Registered 1-to-16 demultiplexer. The data bit IN is routed to the bit of
//   Y selected by S, and every other bit of Y is driven low. The routing is a
//   two-level tree of 1-to-4 cells: S[3:2] picks a group of four outputs and
//   S[1:0] picks the bit inside that group. One flop stage sits on the output,
//   so nothing on the inputs reaches Y combinationally.
//
//   There is no valid/ready handshake on this block. A new S/IN pair is taken
//   on every rising clk edge and its routed result shows up on Y after that
//   same edge (one cycle of latency, one pair per cycle).
//
// Ports
//   clk  in   1   clock, all state updates on the rising edge
//   rst  in   1   synchronous active-high reset, clears Y, wins over S/IN
//   S    in   4   binary index of the destination bit of Y
//   IN   in   1   data bit to be routed
//   Y    out  16  registered one-hot (IN=1) or all-zero (IN=0) output
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// demux_1x4
//   Combinational 1-to-4 demux cell: Y[k] = IN when S == k, else 0.
//
// Ports
//   S    in   2   select
//   IN   in   1   data bit
//   Y    out  4   routed output
// -----------------------------------------------------------------------------
module demux_1x4 (
  input  logic [1:0] S,
  input  logic       IN,
  output logic [3:0] Y
);

  always_comb begin
    Y    = 4'b0000;
    Y[S] = IN;
  end

endmodule

module demux_1x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  S,
  input  logic        IN,
  output logic [15:0] Y
);

  // Group enables from the first stage; at most one is high.
  logic [3:0]  g;
  // Unregistered tree output, d[i] = IN & (S == i).
  logic [15:0] d;

  demux_1x4 u_stage1 (
    .S  (S[3:2]),
    .IN (IN),
    .Y  (g)
  );

  // Cell j covers outputs 4j..4j+3, so S = 0 lands on bit 0 and S = 15 on
  // bit 15.
  for (genvar j = 0; j < 4; j++) begin : g_stage2
    demux_1x4 u_cell (
      .S  (S[1:0]),
      .IN (g[j]),
      .Y  (d[4*j +: 4])
    );
  end

  // The whole word is reloaded each edge, so the previously selected bit
  // clears on the same edge the new one sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y <= 16'h0000;
    end else begin
      Y <= d;
    end
  end

endmodule

// File: tb/tb_demux_1x16.sv
// -----------------------------------------------------------------------------
// tb_demux_1x16
//   Directed bench for demux_1x16. Each step drives rst/S/IN shortly after a
//   rising edge, pushes the value Y must take after the next edge onto
//   exp_q, waits for that edge and compares Y against the popped entry.
// -----------------------------------------------------------------------------
module tb_demux_1x16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  S;
  logic        IN;
  logic [15:0] Y;

  always #5 clk = ~clk;

  demux_1x16 dut (
    .clk (clk),
    .rst (rst),
    .S   (S),
    .IN  (IN),
    .Y   (Y)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model of one edge of the block.
  function automatic logic [15:0] model(input logic r, input logic [3:0] s,
                                        input logic i);
    logic [15:0] one;
    one = 16'h0001;
    if (r)      return 16'h0000;
    else if (i) return one << s;
    else        return 16'h0000;
  endfunction

  task automatic check_out(input string tag);
    logic [15:0] expv;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, Y);
    end else begin
      expv = exp_q.pop_front();
      assert (Y === expv) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", tag, Y, expv);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // Drive one input pair, wait for the edge that samples it, check Y.
  task automatic step(input logic r, input logic [3:0] s, input logic i,
                      input string tag);
    rst = r;
    S   = s;
    IN  = i;
    exp_q.push_back(model(r, s, i));
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic check_onehot(input string tag);
    total++;
    assert ($countones(Y) == 1) else begin
      bad++;
      $error("FAIL %s: observed ones=%0d expected ones=1 (Y=%h)", tag,
             $countones(Y), Y);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    S   = 4'b0101;
    IN  = 1'b1;

    // Reset held for two edges with live inputs, then release.
    step(1'b1, 4'b0101, 1'b1, "reset_0");
    step(1'b1, 4'b0101, 1'b1, "reset_1");
    step(1'b0, 4'b0101, 1'b1, "release");

    // Directed selects.
    step(1'b0, 4'b0000, 1'b1, "sel_0");
    step(1'b0, 4'b1100, 1'b1, "sel_12");
    step(1'b0, 4'b0011, 1'b1, "sel_3");
    step(1'b0, 4'b0100, 1'b1, "sel_4");

    // IN = 0 for every select.
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 4'(k), 1'b0, $sformatf("in0_s%0d", k));
    end

    // Exhaustive sweep with a one-edge reset at S = 10.
    for (int k = 0; k < 16; k++) begin
      if (k == 10) begin
        step(1'b1, 4'(k), 1'b1, "sweep_rst");
      end
      step(1'b0, 4'(k), 1'b1, $sformatf("sweep_s%0d", k));
      check_onehot($sformatf("sweep_onehot_s%0d", k));
    end

    // Back-to-back change of S and IN.
    step(1'b0, 4'b1111, 1'b1, "b2b_15");
    step(1'b0, 4'b0000, 1'b0, "b2b_off");

    // Random pairs, occasional reset.
    for (int k = 0; k < 40; k++) begin
      step(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $sformatf("rand_%0d", k));
    end

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
